// File: rtl/frame_scanout_reader.sv
// frame_scanout_reader: fetches one frame over an Avalon-MM read master into a FIFO and streams it out as valid/ready pixels.
// Ports: clk; reset (async, active-low); start pulse; SD_* Avalon read master (address, read, waitrequest,
// rdata, readdatavalid); pix_valid/pix_ready/pix_r/pix_g/pix_b/pix_last pixel stream; busy, done status;
// underrun_count counts starved busy cycles only when SCANOUT_UNDERRUN_CNT_EN is defined, otherwise reads 0.
module frame_scanout_reader #(
  parameter logic [27:0] BASE_ADDR = 28'h0000000,
  parameter int NUM_PIXELS = 76800,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        SD_read,
  output logic [27:0] SD_address,
  input  logic        SD_waitrequest,
  input  logic [31:0] SD_rdata,
  input  logic        SD_readdatavalid,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        pix_last,
  output logic        busy,
  output logic        done,
  output logic [15:0] underrun_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  state_t state, state_n;
  logic [16:0] req_idx, req_n, pop_idx;
  logic [CW-1:0] outstanding, fifo_count;
  logic [CW:0] credit_n;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [23:0] mem [FIFO_DEPTH];
  logic go, acc, push, pop, last_acc, last_pop, rd_n, unused_bits;
  assign unused_bits = ^SD_rdata[31:24];
  assign go = start & (state == IDLE);
  assign acc = SD_read & ~SD_waitrequest;
  assign push = SD_readdatavalid & (state != IDLE);
  assign pix_valid = fifo_count != '0;
  assign pop = pix_valid & pix_ready;
  assign last_acc = acc & (req_idx == 17'(NUM_PIXELS - 1));
  assign last_pop = pop & (pop_idx == 17'(NUM_PIXELS - 1));
  assign req_n = go ? '0 : req_idx + 17'(acc);
  // Occupancy seen next cycle; a response only moves an entry from outstanding into the FIFO.
  assign credit_n = (CW+1)'(fifo_count) + (CW+1)'(outstanding) + (CW+1)'(acc) - (CW+1)'(pop);
  assign rd_n = (state_n == REQ) & (req_n < 17'(NUM_PIXELS)) & (credit_n < (CW+1)'(FIFO_DEPTH));
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = go ? REQ : (state == REQ && last_acc) ? DRAIN : (state == DRAIN && last_pop) ? IDLE : state;
  always_comb begin
    busy = state != IDLE;
    pix_last = pix_valid & (pop_idx == 17'(NUM_PIXELS - 1));
    {pix_r, pix_g, pix_b} = pix_valid ? mem[rd_ptr] : 24'h0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      SD_read <= 1'b0;
      SD_address <= '0;
      req_idx <= '0;
      pop_idx <= '0;
      outstanding <= '0;
      fifo_count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      done <= 1'b0;
    end else begin
      // A stalled request stays up; req_n does not move, so the address holds too.
      SD_read <= (SD_read & SD_waitrequest) | rd_n;
      SD_address <= BASE_ADDR + {9'h0, req_n, 2'b00};
      req_idx <= req_n;
      pop_idx <= go ? '0 : pop_idx + 17'(pop);
      outstanding <= outstanding + CW'(acc) - CW'(push);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      done <= last_pop & (state == DRAIN);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= SD_rdata[23:0];
`ifdef SCANOUT_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) underrun_count <= '0;
    else if (go) underrun_count <= '0;
    else if (busy & pix_ready & ~pix_valid & (underrun_count != 16'hFFFF)) underrun_count <= underrun_count + 16'd1;
`else
  assign underrun_count = 16'h0000;
`endif
endmodule

// File: tb/tb_frame_scanout_reader.sv
// tb_frame_scanout_reader: randomized scoreboard bench for frame_scanout_reader with an in-bench Avalon slave.
module tb_frame_scanout_reader;
  localparam int NP = 4, FD = 4;
  localparam logic [27:0] BA = 28'h100;
  logic clk = 0, reset = 1, start = 0;
  logic sd_read, sd_wait = 0, sd_rvalid = 0, pix_valid, pix_ready = 0, pix_last, busy, done;
  logic [27:0] sd_addr;
  logic [31:0] sd_rdata = 0;
  logic [7:0] pr, pg, pb;
  logic [15:0] ucnt_dut;
  frame_scanout_reader #(.BASE_ADDR(BA), .NUM_PIXELS(NP), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .start(start),
    .SD_read(sd_read), .SD_address(sd_addr), .SD_waitrequest(sd_wait),
    .SD_rdata(sd_rdata), .SD_readdatavalid(sd_rvalid),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_r(pr), .pix_g(pg), .pix_b(pb),
    .pix_last(pix_last), .busy(busy), .done(done), .underrun_count(ucnt_dut)
  );
  always #5 clk = ~clk;
  typedef struct {int due; logic [31:0] data;} resp_t;
  resp_t rq[$];
  logic [24:0] exp_q[$];
  int tests = 0, fails = 0, cyc = 0;
  int accepted = 0, pushed = 0, popped = 0, done_exp = -1, frames_done = 0;
  int first_acc = 0, last_acc_cyc = 0, last_due = 0, ucnt = 0;
  int lat_lo = 1, lat_hi = 1, wait_pct = 0, ready_pct = 100, noise_pct = 0, wr_force = 0;
  bit busy_m = 0, hold_prev = 0, start_req = 0, stray = 0;
  logic [27:0] prev_addr;
  logic [31:0] seed = 0;

  function automatic logic [31:0] dat(logic [27:0] a, logic [31:0] s);
    return ({4'h0, a} * 32'h9E3779B1) ^ s;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ctl"}, {sd_read, sd_addr, pix_valid, pix_last, busy, done}, 0);
    chk({tag, "_pix"}, {pr, pg, pb, ucnt_dut}, 0);
  endtask

  // Scoreboard/monitor: runs at each negedge, judging the cycle whose posedge comes next.
  task automatic monitor_cycle();
    bit bz, vm, acc;
    int d;
    logic [24:0] e;
    logic [31:0] w;
    bz = busy_m;
    vm = pushed > popped;
    chk("busy", busy, bz);
    chk("pix_valid", pix_valid, vm);
    chk("done", done, cyc == done_exp);
    if (!bz) chk("idle_read", sd_read, 0);
    if (done) begin
      frames_done++;
`ifdef SCANOUT_UNDERRUN_CNT_EN
      chk("underrun", ucnt_dut, ucnt);
`else
      chk("underrun", ucnt_dut, 0);
`endif
    end
    if (bz && pix_ready && !vm && ucnt < 65535) ucnt++;
    if (hold_prev) begin
      chk("hold_read", sd_read, 1);
      chk("hold_addr", sd_addr, prev_addr);
    end
    hold_prev = sd_read && sd_wait;
    prev_addr = sd_addr;
    if (sd_read) chk("credit", accepted - popped < FD, 1);
    acc = sd_read && !sd_wait;
    if (acc) begin
      chk("addr", sd_addr, BA + 28'(4 * accepted));
      chk("req_count", accepted < NP, 1);
      d = cyc + int'($urandom_range(lat_hi, lat_lo));
      last_due = d > last_due ? d : last_due + 1;
      rq.push_back('{due: last_due, data: dat(sd_addr, seed)});
      if (accepted == 0) first_acc = cyc;
      last_acc_cyc = cyc;
      accepted++;
    end
    if (sd_rvalid && bz) pushed++;
    if (pix_valid && pix_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("pixel", {pix_last, pr, pg, pb}, e);
        if (e[24]) begin
          done_exp = cyc + 1;
          busy_m = 0;
        end
      end
      popped++;
    end
    if (start && !bz) begin
      busy_m = 1;
      seed = $urandom;
      accepted = 0; pushed = 0; popped = 0; ucnt = 0; last_due = 0;
      for (int i = 0; i < NP; i++) begin
        w = dat(BA + 28'(4 * i), seed);
        exp_q.push_back({i == NP - 1, w[23:0]});
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) monitor_cycle();
    else hold_prev = 0;
  end

  // Driver: updates inputs 1 time unit after each posedge.
  task automatic step();
    @(posedge clk);
    #1;
    sd_wait = $urandom_range(99) < wait_pct;
    if (wr_force > 0 && accepted == 1 && sd_read) begin
      sd_wait = 1;
      wr_force--;
    end
    pix_ready = $urandom_range(99) < ready_pct;
    start = start_req || (busy && $urandom_range(99) < noise_pct);
    start_req = 0;
    if (rq.size() > 0 && rq[0].due <= cyc + 1) begin
      sd_rvalid = 1;
      sd_rdata = rq[0].data;
      rq.delete(0);
    end else begin
      sd_rvalid = stray;
      sd_rdata = $urandom;
    end
    stray = 0;
  endtask

  task automatic wait_frame(int f0);
    for (int i = 0; i < 3000 && frames_done == f0; i++) step();
    chk("frame_done", frames_done, f0 + 1);
    repeat (2) step();
  endtask

  task automatic run_frame(int wp, int rp, int lo, int hi, int nz);
    int f0;
    f0 = frames_done;
    wait_pct = wp; ready_pct = rp; lat_lo = lo; lat_hi = hi; noise_pct = nz;
    start_req = 1;
    wait_frame(f0);
  endtask

  initial begin
    int f0, lo;
    #2 reset = 0;
    #1 chk_zero("reset");
    repeat (3) step();
    reset = 1;
    repeat (3) step();
    stray = 1;
    repeat (3) step();
    run_frame(0, 100, 1, 1, 0);
    chk("b2b_span", last_acc_cyc - first_acc, NP - 1);
    wr_force = 3;
    run_frame(0, 100, 1, 1, 0);
    chk("wait_forced", wr_force, 0);
    f0 = frames_done;
    wait_pct = 0; ready_pct = 0; lat_lo = 1; lat_hi = 1; noise_pct = 0;
    start_req = 1;
    repeat (20) step();
    chk("full_reqs", accepted, NP);
    chk("full_read", sd_read, 0);
    chk("full_valid", pix_valid, 1);
    chk("full_busy", busy, 1);
    chk("full_nodone", frames_done, f0);
    ready_pct = 100;
    wait_frame(f0);
    run_frame(0, 70, 1, 3, 100);
    run_frame(0, 100, 1, 1, 0);
    run_frame(0, 100, 5, 5, 0);
    wait_pct = 100; ready_pct = 100; noise_pct = 0;
    start_req = 1;
    for (int i = 0; i < 20 && !sd_read; i++) step();
    chk("midreq_read", sd_read, 1);
    step();
    #2 reset = 0;
    #1 chk_zero("midreq_reset");
    rq.delete(); exp_q.delete();
    busy_m = 0; hold_prev = 0; accepted = 0; pushed = 0; popped = 0; done_exp = -1; wait_pct = 0;
    repeat (2) step();
    reset = 1;
    repeat (5) step();
    for (int k = 0; k < 25; k++) begin
      lo = int'($urandom_range(3, 1));
      run_frame(int'($urandom_range(60, 0)), int'($urandom_range(100, 20)), lo, lo + int'($urandom_range(4, 0)), 30);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
